// File: rtl/mux_arb_pkg.sv
// Shared types for the two-requester arbiter: FSM state and requester ids.
package mux_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    typedef logic arb_id_t;

    localparam arb_id_t ARB_ID_0 = 1'b0;
    localparam arb_id_t ARB_ID_1 = 1'b1;

endpackage

// File: rtl/mux_2.sv
// Plain 2:1 select used to steer the current owner's operand onto the shared resource.
module mux_2 #(
    parameter int data_width = 16
) (
    input  logic                  sel,
    input  logic [data_width-1:0] din_0,
    input  logic [data_width-1:0] din_1,
    output logic [data_width-1:0] dout
);

    assign dout = sel ? din_1 : din_0;

endmodule

// File: rtl/mux_arbiter_2.sv
// Round-robin arbiter/sequencer for one shared single-ported resource with completion timeout.
// Optional per-requester saturating grant counters are enabled with `define MUX_ARB_GRANT_CNT_EN.
module mux_arbiter_2
    import mux_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 15,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_0,
    input  logic                  req_1,
    input  logic [DATA_WIDTH-1:0] din_0,
    input  logic [DATA_WIDTH-1:0] din_1,
    input  logic                  port_ready,
    output logic [DATA_WIDTH-1:0] port_out,
    output logic                  port_valid,
    output logic                  port_sel,
    output logic                  gnt_0,
    output logic                  gnt_1,
    output logic                  done_0,
    output logic                  done_1,
    output logic                  err_0,
    output logic                  err_1
`ifdef MUX_ARB_GRANT_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  gnt_cnt_0,
    output logic [CNT_WIDTH-1:0]  gnt_cnt_1
`endif
);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    arb_state_t           state, state_n;
    arb_id_t              last_owner, last_owner_n;
    arb_id_t              sel_n, winner, other;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic                 valid_n, other_req, finish, new_grant;
    logic                 done_0_n, done_1_n, err_0_n, err_1_n;

    mux_2 #(
        .data_width(DATA_WIDTH)
    ) u_mux (
        .sel  (port_sel),
        .din_0(din_0),
        .din_1(din_1),
        .dout (port_out)
    );

    // Completion and timeout both end the transaction; port_ready has priority.
    always_comb begin
        state_n      = state;
        sel_n        = port_sel;
        valid_n      = port_valid;
        last_owner_n = last_owner;
        cnt_n        = cnt;
        done_0_n     = 1'b0;
        done_1_n     = 1'b0;
        err_0_n      = 1'b0;
        err_1_n      = 1'b0;
        new_grant    = 1'b0;
        winner       = ARB_ID_0;
        other        = ~port_sel;
        other_req    = (other == ARB_ID_1) ? req_1 : req_0;
        finish       = port_ready || (cnt == TIMEOUT_LAST);

        case (state)
            ARB_IDLE: begin
                if (req_0 || req_1) begin
                    if (req_0 && req_1)
                        winner = ~last_owner;
                    else if (req_1)
                        winner = ARB_ID_1;
                    else
                        winner = ARB_ID_0;
                    state_n   = ARB_BUSY;
                    sel_n     = winner;
                    valid_n   = 1'b1;
                    cnt_n     = '0;
                    new_grant = 1'b1;
                end
            end
            ARB_BUSY: begin
                if (finish) begin
                    if (port_ready) begin
                        done_0_n = (port_sel == ARB_ID_0);
                        done_1_n = (port_sel == ARB_ID_1);
                    end else begin
                        err_0_n = (port_sel == ARB_ID_0);
                        err_1_n = (port_sel == ARB_ID_1);
                    end
                    last_owner_n = port_sel;
                    cnt_n        = '0;
                    // Hand straight over to a waiting requester without an IDLE bubble.
                    if (other_req) begin
                        sel_n     = other;
                        new_grant = 1'b1;
                    end else begin
                        state_n = ARB_IDLE;
                        valid_n = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + CNT_WIDTH'(1);
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    // Reset leaves last_owner at 1 so requester 0 wins the first contested round.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_owner <= ARB_ID_1;
            cnt        <= '0;
            port_sel   <= ARB_ID_0;
            port_valid <= 1'b0;
            gnt_0      <= 1'b0;
            gnt_1      <= 1'b0;
            done_0     <= 1'b0;
            done_1     <= 1'b0;
            err_0      <= 1'b0;
            err_1      <= 1'b0;
        end else begin
            state      <= state_n;
            last_owner <= last_owner_n;
            cnt        <= cnt_n;
            port_sel   <= sel_n;
            port_valid <= valid_n;
            gnt_0      <= valid_n && (sel_n == ARB_ID_0);
            gnt_1      <= valid_n && (sel_n == ARB_ID_1);
            done_0     <= done_0_n;
            done_1     <= done_1_n;
            err_0      <= err_0_n;
            err_1      <= err_1_n;
        end
    end

`ifdef MUX_ARB_GRANT_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_cnt_0 <= '0;
            gnt_cnt_1 <= '0;
        end else if (new_grant) begin
            if (sel_n == ARB_ID_0 && gnt_cnt_0 != '1)
                gnt_cnt_0 <= gnt_cnt_0 + CNT_WIDTH'(1);
            if (sel_n == ARB_ID_1 && gnt_cnt_1 != '1)
                gnt_cnt_1 <= gnt_cnt_1 + CNT_WIDTH'(1);
        end
    end
`else
    logic unused_new_grant;
    assign unused_new_grant = new_grant;
`endif

endmodule

// File: tb/tb_mux_arbiter_2.sv
// Directed bench for mux_arbiter_2: vector table for single/contested grants, hand sequences for
// timeout, ready-vs-timeout, async reset and (with MUX_ARB_GRANT_CNT_EN) grant counter saturation.
module tb_mux_arbiter_2;

    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic          req_0, req_1, port_ready;
    logic [DW-1:0] din_0, din_1, port_out;
    logic          port_valid, port_sel, gnt_0, gnt_1, done_0, done_1, err_0, err_1;
`ifdef MUX_ARB_GRANT_CNT_EN
    logic [7:0]    gnt_cnt_0, gnt_cnt_1;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic        r0;
        logic        r1;
        logic        rdy;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [7:0]  flags;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs [16];

    mux_arbiter_2 #(
        .DATA_WIDTH(DW),
        .TIMEOUT   (15),
        .CNT_WIDTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_0     (req_0),
        .req_1     (req_1),
        .din_0     (din_0),
        .din_1     (din_1),
        .port_ready(port_ready),
        .port_out  (port_out),
        .port_valid(port_valid),
        .port_sel  (port_sel),
        .gnt_0     (gnt_0),
        .gnt_1     (gnt_1),
        .done_0    (done_0),
        .done_1    (done_1),
        .err_0     (err_0),
        .err_1     (err_1)
`ifdef MUX_ARB_GRANT_CNT_EN
        ,
        .gnt_cnt_0 (gnt_cnt_0),
        .gnt_cnt_1 (gnt_cnt_1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output flags packed as {gnt_0, gnt_1, port_valid, port_sel, done_0, done_1, err_0, err_1}.
    function automatic logic [7:0] out_flags();
        return {gnt_0, gnt_1, port_valid, port_sel, done_0, done_1, err_0, err_1};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected)
            checks_passed++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_0      = 1'b0;
        req_1      = 1'b0;
        port_ready = 1'b0;
        din_0      = '0;
        din_1      = '0;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        req_0      = v.r0;
        req_1      = v.r1;
        port_ready = v.rdy;
        din_0      = v.d0;
        din_1      = v.d1;
        step();
    endtask

    initial begin
        // Vectors 0-5: lone requester 0; vectors 6-15: both requesters held, round-robin handover.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h00A5, 16'h0000, 8'b1010_0000, 16'h00A5};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h00A5, 16'h0000, 8'b1010_0000, 16'h00A5};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h00A5, 16'h0000, 8'b1010_0000, 16'h00A5};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 16'h00A5, 16'h0000, 8'b0000_1000, 16'h00A5};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h00A5, 16'h0000, 8'b0000_0000, 16'h00A5};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h00A5, 16'h0000, 8'b0000_0000, 16'h00A5};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 8'b1010_0000, 16'h1111};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222, 8'b0111_1000, 16'h2222};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 8'b0111_0000, 16'h2222};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222, 8'b1010_0100, 16'h1111};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 8'b1010_0000, 16'h1111};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222, 8'b0111_1000, 16'h2222};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 8'b0111_0000, 16'h2222};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222, 8'b1010_0100, 16'h1111};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 16'h1111, 16'h2222, 8'b0000_1000, 16'h1111};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222, 8'b0000_0000, 16'h1111};

        reset      = 1'b1;
        req_0      = 1'b0;
        req_1      = 1'b0;
        port_ready = 1'b0;
        din_0      = '0;
        din_1      = '0;
        #3;
        check_output("reset_state", {24'h0, out_flags()}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            if (i == 0 || i == 6)
                do_reset();
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d", i), {8'h0, out_flags(), port_out},
                         {8'h0, vecs[i].flags, vecs[i].exp_out});
        end

        // Requester 1 never sees port_ready: err_1 after the 15th BUSY cycle.
        do_reset();
        req_1 = 1'b1;
        din_1 = 16'hBEEF;
        step();
        check_output("timeout_grant", {8'h0, out_flags(), port_out}, {8'h0, 8'b0111_0000, 16'hBEEF});
        for (int k = 2; k <= 15; k++) begin
            step();
            check_output($sformatf("timeout_busy%0d", k), {24'h0, out_flags()}, {24'h0, 8'b0111_0000});
        end
        step();
        check_output("timeout_err", {24'h0, out_flags()}, {24'h0, 8'b0001_0001});
        req_1 = 1'b0;
        step();
        check_output("timeout_idle", {24'h0, out_flags()}, {24'h0, 8'b0001_0000});

        // port_ready arrives on the same cycle the timeout would fire: done wins.
        do_reset();
        req_0 = 1'b1;
        din_0 = 16'h0C0D;
        step();
        check_output("race_grant", {8'h0, out_flags(), port_out}, {8'h0, 8'b1010_0000, 16'h0C0D});
        for (int k = 2; k <= 15; k++) begin
            step();
            check_output($sformatf("race_busy%0d", k), {24'h0, out_flags()}, {24'h0, 8'b1010_0000});
        end
        port_ready = 1'b1;
        step();
        check_output("race_done", {24'h0, out_flags()}, {24'h0, 8'b0000_1000});
        req_0 = 1'b0;
        step();
        check_output("idle_ready_ignored", {24'h0, out_flags()}, 32'h0);
        port_ready = 1'b0;

        // Async reset mid-transaction, then a contested request goes to requester 0.
        do_reset();
        req_1 = 1'b1;
        din_0 = 16'h1234;
        din_1 = 16'h5A5A;
        step();
        step();
        check_output("pre_reset_busy", {8'h0, out_flags(), port_out}, {8'h0, 8'b0111_0000, 16'h5A5A});
        #2;
        reset = 1'b1;
        #1;
        check_output("async_reset", {8'h0, out_flags(), port_out}, {8'h0, 8'b0000_0000, 16'h1234});
        req_0 = 1'b1;
        #2;
        reset = 1'b0;
        step();
        check_output("post_reset_contest", {8'h0, out_flags(), port_out}, {8'h0, 8'b1010_0000, 16'h1234});

`ifdef MUX_ARB_GRANT_CNT_EN
        // 300 grants to requester 0: two cycles per grant with req and ready held high.
        do_reset();
        req_0      = 1'b1;
        port_ready = 1'b1;
        repeat (600) step();
        check_output("gnt_cnt_0_sat", {24'h0, gnt_cnt_0}, 32'd255);
        check_output("gnt_cnt_1_zero", {24'h0, gnt_cnt_1}, 32'd0);
        req_0      = 1'b0;
        port_ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
